dmem_sram_like_bridge: RTL

//  Sits directly downstream of the datapath memory stage.

---
 rtl/dmem_sram_like_bridge_pkg.sv | 41 ++++
 rtl/dmem_sram_like_bridge.sv | 108 ++++++++++
 2 files changed

// File: rtl/dmem_sram_like_bridge_pkg.sv
// Shared types and helpers for the data-memory to sram-like bus bridge.
package dmem_sram_like_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DATA = 2'd1,
        ST_DONE      = 2'd2
    } bridgeState_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef struct packed {
        logic       legal;
        logic [1:0] size;
        logic [1:0] offset;
    } wenDecode_t;

    // A read (wen == 0) is always a full aligned word; writes map the
    // byte-enable pattern to a transfer size and the lowest enabled lane.
    function automatic wenDecode_t decodeWen(input logic [3:0] wen);
        wenDecode_t d;
        d.legal  = 1'b1;
        d.size   = SIZE_WORD;
        d.offset = 2'd0;
        case (wen)
            4'b0000: begin d.size = SIZE_WORD; d.offset = 2'd0; end
            4'b1111: begin d.size = SIZE_WORD; d.offset = 2'd0; end
            4'b0011: begin d.size = SIZE_HALF; d.offset = 2'd0; end
            4'b1100: begin d.size = SIZE_HALF; d.offset = 2'd2; end
            4'b0001: begin d.size = SIZE_BYTE; d.offset = 2'd0; end
            4'b0010: begin d.size = SIZE_BYTE; d.offset = 2'd1; end
            4'b0100: begin d.size = SIZE_BYTE; d.offset = 2'd2; end
            4'b1000: begin d.size = SIZE_BYTE; d.offset = 2'd3; end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/dmem_sram_like_bridge.sv
// Bridges the single-cycle M-stage data-memory port onto a split-transaction
// sram-like bus, stalling the pipeline until each access completes.
//
// state        | meaning
// ST_IDLE      | request driven straight from the M-stage inputs, waiting for addr_ok
// ST_WAIT_DATA | request accepted, waiting for data_ok
// ST_DONE      | access finished but pipeline frozen elsewhere; hold read data, no bus activity
module dmem_sram_like_bridge
    import dmem_sram_like_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_en,
    input  logic [3:0]        mem_wen,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              pipe_stall,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              d_stall,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata
);

    bridgeState_t      state;
    bridgeState_t      stateNext;
    logic [DATA_W-1:0] rdataQ;
    logic              completing;
    logic              busReq;
    logic              fieldEn;
    wenDecode_t        wenDec;

    assign wenDec  = decodeWen(mem_wen);
    assign fieldEn = ~rst & mem_en;

    // State register and read-data hold; the hold register only loads on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            rdataQ <= '0;
        end else begin
            state <= stateNext;
            if (completing) begin
                rdataQ <= data_rdata;
            end
        end
    end

    // Next-state decode; a same-cycle addr_ok+data_ok in IDLE completes like WAIT_DATA would.
    always_comb begin
        stateNext  = state;
        completing = 1'b0;
        busReq     = 1'b0;
        case (state)
            ST_IDLE: begin
                busReq = mem_en;
                if (mem_en && data_addr_ok) begin
                    if (data_data_ok) begin
                        completing = 1'b1;
                        stateNext  = pipe_stall ? ST_DONE : ST_IDLE;
                    end else begin
                        stateNext = ST_WAIT_DATA;
                    end
                end
            end
            ST_WAIT_DATA: begin
                if (data_data_ok) begin
                    completing = 1'b1;
                    stateNext  = pipe_stall ? ST_DONE : ST_IDLE;
                end
            end
            ST_DONE: begin
                if (!pipe_stall) begin
                    stateNext = ST_IDLE;
                end
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    // Request fields follow the M-stage inputs, which stay frozen while we stall.
    assign data_req   = ~rst & busReq;
    assign data_wr    = fieldEn & (|mem_wen);
    assign data_size  = fieldEn ? wenDec.size : 2'd0;
    assign data_addr  = fieldEn ? ((mem_addr & ~ADDR_W'(3)) | ADDR_W'(wenDec.offset)) : '0;
    assign data_wdata = fieldEn ? mem_wdata : '0;

    // Completion cycle bypasses the bus data so a zero-wait bus costs no stall.
    assign d_stall   = fieldEn & ~completing & (state != ST_DONE);
    assign mem_rdata = rst ? '0 : (completing ? data_rdata : rdataQ);

    // Byte-enable patterns the bus cannot express, and completions with nothing outstanding.
    assertLegalWen: assert property (@(posedge clk) disable iff (rst)
        (mem_en && state == ST_IDLE) |-> wenDec.legal);

    assertNoOrphanDataOk: assert property (@(posedge clk) disable iff (rst)
        data_data_ok |-> ((state == ST_WAIT_DATA) ||
                          (state == ST_IDLE && mem_en && data_addr_ok)));

endmodule
